// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// The MMIO offsets only matter when DMEM_MMIO_EN is defined.
package dmem_pkg;

  localparam logic [7:0] GPIO_OFS   = 8'h00;
  localparam logic [7:0] CYCLE_OFS  = 8'h04;
  localparam logic [7:0] TOHOST_OFS = 8'h08;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_NONE
  } dec_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous read-first read and full-word write.
// The plain array with a registered read maps onto FPGA block RAM.
module dmem_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // The read samples the array before this edge's write lands, so the old word is returned.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus, with DMEM_MMIO_EN defined, a GPIO,
// cycle-counter and tohost/halt register window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dec_e        dec_d, dec_q;
  logic        misaligned;
  logic        mmio_store_ok;
  logic        store_ok;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata_d, mmio_rdata_q;
  logic        err_q;

  assign misaligned = (mem_addr[1:0] != 2'b00);

  always_comb begin
    dec_d = DEC_NONE;
    if (mem_addr[31:AW+2] == '0) begin
      dec_d = DEC_RAM;
    end
`ifdef DMEM_MMIO_EN
    else if (mem_addr[31:8] == MMIO_BASE[31:8]) begin
      dec_d = DEC_MMIO;
    end
`endif
  end

`ifdef DMEM_MMIO_EN
  logic [7:0]  mmio_ofs;
  logic        wr_gpio, wr_tohost;
  logic [31:0] gpio_q, cycle_q, halt_code_q;
  logic        halt_q;

  assign mmio_ofs  = mem_addr[7:0];
  assign wr_gpio   = mem_write && (dec_d == DEC_MMIO) && (mmio_ofs == GPIO_OFS);
  assign wr_tohost = mem_write && (dec_d == DEC_MMIO) && (mmio_ofs == TOHOST_OFS);
  assign mmio_store_ok = wr_gpio || wr_tohost;

  // Reads ignore the byte offset, matching the RAM path.
  always_comb begin
    mmio_rdata_d = 32'h0;
    if (mmio_ofs[7:2] == GPIO_OFS[7:2]) begin
      mmio_rdata_d = gpio_q;
    end else if (mmio_ofs[7:2] == CYCLE_OFS[7:2]) begin
      mmio_rdata_d = cycle_q;
    end else if (mmio_ofs[7:2] == TOHOST_OFS[7:2]) begin
      mmio_rdata_d = halt_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q      <= 32'h0;
      cycle_q     <= 32'h0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
    end else begin
      if (wr_gpio) begin
        gpio_q <= mem_wdata;
      end
      if (wr_tohost) begin
        halt_code_q <= mem_wdata;
        if (mem_wdata != 32'h0) begin
          halt_q <= 1'b1;
        end
      end
      if (!halt_q) begin
        cycle_q <= cycle_q + 32'd1;
      end
    end
  end

  assign gpio_out  = gpio_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
`else
  assign mmio_store_ok = 1'b0;
  assign mmio_rdata_d  = 32'h0;
  assign gpio_out      = 32'h0;
  assign halt          = 1'b0;
  assign halt_code     = 32'h0;
`endif

  // Misalignment vetoes both RAM and MMIO stores.
  assign store_ok = !misaligned && ((dec_d == DEC_RAM) || mmio_store_ok);
  assign ram_we   = mem_write && !reset && !misaligned && (dec_d == DEC_RAM);

  dmem_ram #(
    .Depth (DEPTH_WORDS),
    .Aw    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (mem_addr[AW+1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q        <= DEC_NONE;
      mmio_rdata_q <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      dec_q        <= dec_d;
      mmio_rdata_q <= mmio_rdata_d;
      if (mem_write && !store_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    unique case (dec_q)
      DEC_RAM:  mem_rdata = ram_rdata;
      DEC_MMIO: mem_rdata = mmio_rdata_q;
      default:  mem_rdata = 32'h0;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expectations, a monitor
// compares them one edge later. MMIO checks are built only with DMEM_MMIO_EN.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MBASE = 32'hFFFF_FF00;

  typedef enum int {K_RDATA, K_ERR, K_GPIO, K_HALT, K_CODE} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] gpio_out;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (MBASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .gpio_out  (gpio_out),
    .halt      (halt),
    .halt_code (halt_code),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                      input logic w);
    @(negedge clk);
    reset     = rst;
    mem_addr  = a;
    mem_wdata = d;
    mem_write = w;
  endtask

  // Expectation on the state after the next posedge.
  task automatic expect_val(input string n, input kind_e k, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.kind = k;
    it.exp  = v;
    sb.push_back(it);
  endtask

  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_RDATA: act = mem_rdata;
          K_ERR:   act = {31'h0, err};
          K_GPIO:  act = gpio_out;
          K_HALT:  act = {31'h0, halt};
          default: act = halt_code;
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    step(1, 32'h0, 32'h0, 0);
    step(1, 32'h0, 32'h0, 0);
    expect_val("rst_rdata", K_RDATA, 32'h0);
    expect_val("rst_err", K_ERR, 32'h0);
    expect_val("rst_gpio", K_GPIO, 32'h0);
    expect_val("rst_halt", K_HALT, 32'h0);
    expect_val("rst_code", K_CODE, 32'h0);

    // Store then load, with byte offset ignored on read
    step(0, 32'h0000_0008, 32'hDEAD_BEEF, 1);
    expect_val("sw_ok_err", K_ERR, 32'h0);
    step(0, 32'h0000_0008, 32'h0, 0);
    expect_val("lw_8", K_RDATA, 32'hDEAD_BEEF);
    step(0, 32'h0000_000B, 32'h0, 0);
    expect_val("lw_b_offset", K_RDATA, 32'hDEAD_BEEF);

    // Read-first on same-cycle store/read
    step(0, 32'h0000_0010, 32'hAAAA_AAAA, 1);
    step(0, 32'h0000_0010, 32'h1111_1111, 1);
    expect_val("read_first_old", K_RDATA, 32'hAAAA_AAAA);
    step(0, 32'h0000_0010, 32'h0, 0);
    expect_val("read_first_new", K_RDATA, 32'h1111_1111);

    // Top word and just past the end
    step(0, 32'h0000_0FFC, 32'h1234_5678, 1);
    step(0, 32'h0000_0FFC, 32'h0, 0);
    expect_val("lw_top", K_RDATA, 32'h1234_5678);
    step(0, 32'h0000_1000, 32'h0, 0);
    expect_val("lw_oob_zero", K_RDATA, 32'h0);
    expect_val("oob_read_no_err", K_ERR, 32'h0);

    // Misaligned store: err set, RAM unchanged
    step(0, 32'h0000_0000, 32'h0C0F_FEE0, 1);
    step(0, 32'h0000_0002, 32'hBAD0_0001, 1);
    expect_val("misaligned_err", K_ERR, 32'h1);
    step(0, 32'h0000_0000, 32'h0, 0);
    expect_val("misaligned_ram", K_RDATA, 32'h0C0F_FEE0);
    step(1, 32'h0, 32'h0, 0);
    expect_val("err_cleared", K_ERR, 32'h0);

    // Out-of-range store must not alias into word 0
    step(0, 32'h0000_1000, 32'hBAD0_0002, 1);
    expect_val("oob_err", K_ERR, 32'h1);
    step(0, 32'h0000_0000, 32'h0, 0);
    expect_val("oob_ram", K_RDATA, 32'h0C0F_FEE0);
    expect_val("err_sticky", K_ERR, 32'h1);
    step(1, 32'h0, 32'h0, 0);

    // Store to CYCLE: read-only with MMIO, out of range without
    step(0, MBASE + 32'h4, 32'h0000_0055, 1);
    expect_val("cycle_store_err", K_ERR, 32'h1);
    step(1, 32'h0, 32'h0, 0);
    expect_val("err_cleared2", K_ERR, 32'h0);

`ifdef DMEM_MMIO_EN
    step(0, MBASE, 32'h0000_005A, 1);
    expect_val("gpio_out", K_GPIO, 32'h0000_005A);
    expect_val("gpio_err", K_ERR, 32'h0);
    step(0, MBASE, 32'h0, 0);
    expect_val("gpio_read", K_RDATA, 32'h0000_005A);
    step(0, MBASE + 32'hC, 32'h0, 0);
    expect_val("mmio_hole_read", K_RDATA, 32'h0);

    // Counter wrap
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_q;
    mem_addr = MBASE + 32'h4;
    expect_val("cycle_fffe", K_RDATA, 32'hFFFF_FFFE);
    step(0, MBASE + 32'h4, 32'h0, 0);
    expect_val("cycle_ffff", K_RDATA, 32'hFFFF_FFFF);
    step(0, MBASE + 32'h4, 32'h0, 0);
    expect_val("cycle_wrap", K_RDATA, 32'h0);

    // TOHOST: zero does not halt, nonzero halts and freezes the counter at 3
    step(0, MBASE + 32'h8, 32'h0, 1);
    expect_val("tohost0_halt", K_HALT, 32'h0);
    expect_val("tohost0_code", K_CODE, 32'h0);
    step(0, MBASE + 32'h8, 32'h1, 1);
    expect_val("tohost1_halt", K_HALT, 32'h1);
    expect_val("tohost1_code", K_CODE, 32'h1);
    step(0, MBASE + 32'h4, 32'h0, 0);
    expect_val("cycle_frozen_a", K_RDATA, 32'h3);
    step(0, MBASE + 32'h4, 32'h0, 0);
    expect_val("cycle_frozen_b", K_RDATA, 32'h3);
    step(0, MBASE + 32'h8, 32'h7, 1);
    expect_val("tohost7_code", K_CODE, 32'h7);
    expect_val("halt_sticky", K_HALT, 32'h1);
    step(0, MBASE + 32'h10, 32'h1, 1);
    expect_val("mmio_hole_err", K_ERR, 32'h1);
`else
    step(0, MBASE + 32'h8, 32'h1, 1);
    expect_val("nommio_tohost_err", K_ERR, 32'h1);
    expect_val("nommio_halt", K_HALT, 32'h0);
    expect_val("nommio_code", K_CODE, 32'h0);
    step(0, MBASE, 32'h0000_005A, 1);
    expect_val("nommio_gpio", K_GPIO, 32'h0);
    step(0, MBASE, 32'h0, 0);
    expect_val("nommio_read", K_RDATA, 32'h0);
`endif

    // Reset mid-op with a pending store to word 1
    step(0, 32'h0000_0004, 32'h4444_4444, 1);
    step(1, 32'h0000_0004, 32'h9999_9999, 1);
    expect_val("midrst_rdata", K_RDATA, 32'h0);
    expect_val("midrst_err", K_ERR, 32'h0);
    expect_val("midrst_gpio", K_GPIO, 32'h0);
    expect_val("midrst_halt", K_HALT, 32'h0);
    expect_val("midrst_code", K_CODE, 32'h0);
    step(0, 32'h0000_0004, 32'h0, 0);
    expect_val("midrst_ram", K_RDATA, 32'h4444_4444);

    step(0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
